// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spi_pkg
// Purpose : Shared constants for the SPI shift engine. Holds the FSM state
//           encoding, the CPOL/CPHA mode pairs and a counter-width helper.
// Revision: 1.0 - initial parametrised release
// ============================================================================
package spi_pkg;

   // FSM state encoding
   localparam logic [2:0] c_ST_IDLE  = 3'd0;
   localparam logic [2:0] c_ST_LEAD  = 3'd1;
   localparam logic [2:0] c_ST_SHIFT = 3'd2;
   localparam logic [2:0] c_ST_TRAIL = 3'd3;
   localparam logic [2:0] c_ST_DONE  = 3'd4;

   // SPI modes as {CPOL, CPHA}
   localparam logic [1:0] c_MODE0 = 2'b00;
   localparam logic [1:0] c_MODE1 = 2'b01;
   localparam logic [1:0] c_MODE2 = 2'b10;
   localparam logic [1:0] c_MODE3 = 2'b11;

   // Width of a counter that must hold values 0..n-1 without wrapping,
   // with one spare bit of headroom.
   function automatic int cnt_width(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/spi_clk_gen.sv
`default_nettype none
// ============================================================================
// Module  : spi_clk_gen
// Purpose : SCLK divider. Counts CLK_DIV system cycles per half period while
//           counting is enabled, toggles SCLK on each tick while SCLK is
//           enabled, and flags leading/trailing edges with one-cycle strobes.
//           SCLK is parked at CPOL whenever it is not enabled.
// Revision: 1.0 - initial parametrised release
// ============================================================================
module spi_clk_gen
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter bit CPOL    = 1'b1
) (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic cnt_en_i,
   input  logic sclk_en_i,
   output logic tick_o,
   output logic lead_stb_o,
   output logic trail_stb_o,
   output logic sclk_o
);

   localparam int                 c_DIV_W    = cnt_width(CLK_DIV);
   localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
   localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);

   logic [c_DIV_W-1:0] r_div_cnt;
   logic               r_sclk;

   // A tick marks the last cycle of each half period; edges are qualified
   // by the current SCLK level so the engine knows which edge is coming.
   assign tick_o      = cnt_en_i && (r_div_cnt == c_DIV_LAST);
   assign lead_stb_o  = tick_o && sclk_en_i && (r_sclk == CPOL);
   assign trail_stb_o = tick_o && sclk_en_i && (r_sclk != CPOL);
   assign sclk_o      = r_sclk;

   // Half-period counter: restarts on every tick and holds at zero when idle
   always_ff @(posedge clk_i) begin
      if (!rstn_i || !cnt_en_i || tick_o) begin
         r_div_cnt <= '0;
      end else begin
         r_div_cnt <= r_div_cnt + c_DIV_ONE;
      end
   end

   // SCLK register: toggles on ticks while enabled, otherwise parked at CPOL
   always_ff @(posedge clk_i) begin
      if (!rstn_i || !sclk_en_i) begin
         r_sclk <= CPOL;
      end else if (tick_o) begin
         r_sclk <= ~r_sclk;
      end
   end

endmodule
`default_nettype wire

// File: rtl/spi_shift_engine.sv
`default_nettype none
// ============================================================================
// Module  : spi_shift_engine
// Purpose : Full-duplex SPI master shift engine. Any word width, all four
//           CPOL/CPHA modes, either bit order, chip-select sequencing.
//           Optional build macro SPI_SHIFT_ENGINE_LOOPBACK_EN adds loopback_i,
//           which feeds the outgoing bit back into the receiver and keeps
//           chip-select deasserted.
// Revision: 1.0 - initial parametrised release
// ============================================================================
module spi_shift_engine
   import spi_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int CLK_DIV   = 4,
   parameter bit CPOL      = 1'b1,
   parameter bit CPHA      = 1'b1,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              start_i,
   input  logic [DATA_W-1:0] tx_data_i,
   output logic [DATA_W-1:0] rx_data_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              cs_n_o,
   output logic              sclk_o,
   output logic              mosi_o,
   input  logic              miso_i
`ifdef SPI_SHIFT_ENGINE_LOOPBACK_EN
   ,
   input  logic              loopback_i
`endif
);

   localparam logic [1:0]         c_MODE        = {CPOL, CPHA};
   localparam bit                 c_SAMPLE_LEAD = (c_MODE == c_MODE0) || (c_MODE == c_MODE2);
   localparam bit                 c_SAMPLE_TRAIL = (c_MODE == c_MODE1) || (c_MODE == c_MODE3);
   localparam int                 c_BIT_W       = cnt_width(DATA_W);
   localparam logic [c_BIT_W-1:0] c_BIT_LAST    = c_BIT_W'(DATA_W - 1);
   localparam logic [c_BIT_W-1:0] c_BIT_ONE     = c_BIT_W'(1);

   logic [2:0]         r_state;
   logic [2:0]         w_next;
   logic [DATA_W-1:0]  r_shift;
   logic [c_BIT_W-1:0] r_bit_cnt;
   logic               r_mosi;
   logic [DATA_W-1:0]  r_rx;

   logic               w_cnt_en;
   logic               w_sclk_en;
   logic               w_tick;
   logic               w_lead;
   logic               w_trail;
   logic               w_last_trail;
   logic               w_sample;
   logic               w_drive;
   logic               w_sdi;
   logic               w_out_bit;
   logic               w_tx_first;
   logic [DATA_W-1:0]  w_shift_in;

   spi_clk_gen #(
      .CLK_DIV (CLK_DIV),
      .CPOL    (CPOL)
   ) u_clk_gen (
      .clk_i       (clk_i),
      .rstn_i      (rstn_i),
      .cnt_en_i    (w_cnt_en),
      .sclk_en_i   (w_sclk_en),
      .tick_o      (w_tick),
      .lead_stb_o  (w_lead),
      .trail_stb_o (w_trail),
      .sclk_o      (sclk_o)
   );

`ifdef SPI_SHIFT_ENGINE_LOOPBACK_EN
   assign w_sdi = loopback_i ? r_mosi : miso_i;
`else
   assign w_sdi = miso_i;
`endif

   // The outgoing bit sits at the end we shift away from; the sampled bit
   // fills the vacated opposite end, so the RX word lands in order.
   assign w_out_bit    = MSB_FIRST ? r_shift[DATA_W-1] : r_shift[0];
   assign w_tx_first   = MSB_FIRST ? tx_data_i[DATA_W-1] : tx_data_i[0];
   assign w_shift_in   = MSB_FIRST ? {r_shift[DATA_W-2:0], w_sdi}
                                   : {w_sdi, r_shift[DATA_W-1:1]};
   assign w_last_trail = w_trail && (r_bit_cnt == c_BIT_LAST);
   // CPHA=0 samples on leading edges and drives on all but the last trailing
   // edge (the first bit is already out from LEAD); CPHA=1 drives on leading
   // edges and samples on trailing edges.
   assign w_sample     = c_SAMPLE_LEAD ? w_lead : (c_SAMPLE_TRAIL && w_trail);
   assign w_drive      = c_SAMPLE_LEAD ? (w_trail && !w_last_trail) : w_lead;

   // State register
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic: LEAD and TRAIL each last one half period
   always_comb begin
      w_next = r_state;
      case (r_state)
         c_ST_IDLE:  if (start_i)      w_next = c_ST_LEAD;
         c_ST_LEAD:  if (w_tick)       w_next = c_ST_SHIFT;
         c_ST_SHIFT: if (w_last_trail) w_next = c_ST_TRAIL;
         c_ST_TRAIL: if (w_tick)       w_next = c_ST_DONE;
         c_ST_DONE:                    w_next = c_ST_IDLE;
         default:                      w_next = c_ST_IDLE;
      endcase
   end

   // Output decode from state
   always_comb begin
      busy_o    = (r_state != c_ST_IDLE);
      done_o    = (r_state == c_ST_DONE);
      w_cnt_en  = (r_state == c_ST_LEAD) || (r_state == c_ST_SHIFT) || (r_state == c_ST_TRAIL);
      w_sclk_en = (r_state == c_ST_SHIFT);
      cs_n_o    = !w_cnt_en;
`ifdef SPI_SHIFT_ENGINE_LOOPBACK_EN
      if (loopback_i) begin
         cs_n_o = 1'b1;
      end
`endif
   end

   // Datapath: shared TX/RX shift register, bit counter, MOSI and RX word.
   // The RX word is captured as TRAIL ends so it is already valid while
   // done_o is high.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_mosi    <= 1'b0;
         r_rx      <= '0;
      end else if (r_state == c_ST_IDLE) begin
         if (start_i) begin
            r_shift   <= tx_data_i;
            r_bit_cnt <= '0;
            r_mosi    <= CPHA ? 1'b0 : w_tx_first;
         end
      end else begin
         if (w_sample) begin
            r_shift <= w_shift_in;
         end
         if (w_trail) begin
            r_bit_cnt <= r_bit_cnt + c_BIT_ONE;
         end
         if (w_drive) begin
            r_mosi <= w_out_bit;
         end
         if ((r_state == c_ST_TRAIL) && w_tick) begin
            r_rx   <= r_shift;
            r_mosi <= 1'b0;
         end
      end
   end

   assign mosi_o    = r_mosi;
   assign rx_data_o = r_rx;

endmodule
`default_nettype wire

// File: tb/tb_spi_shift_engine.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_shift_engine
// Purpose : Self-checking bench for spi_shift_engine. Three configurations
//           (mode 3 MSB-first 8/2, mode 0 MSB-first 8/2, mode 2 LSB-first
//           16/1) each talk to a bit-level SPI slave model that serves a
//           random word on MISO and records what arrives on MOSI.
// Revision: 1.0 - initial release
// ============================================================================
module tb_spi_shift_engine;

   localparam int c_NCFG = 3;
   localparam int c_W   [c_NCFG] = '{8, 8, 16};
   localparam int c_D   [c_NCFG] = '{2, 2, 1};
   localparam int c_POL [c_NCFG] = '{1, 0, 1};
   localparam int c_PHA [c_NCFG] = '{1, 0, 0};
   localparam int c_MSB [c_NCFG] = '{1, 1, 0};
   localparam int c_TX0 [c_NCFG] = '{32'h00A5, 32'h0081, 32'h0001};
   localparam int c_SW0 [c_NCFG] = '{32'h003C, 32'h00FF, 32'hB7E2};

   logic clk = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   for (genvar g = 0; g < c_NCFG; g++) begin : g_cfg
      localparam int c_DW   = c_W[g];
      localparam int c_DV   = c_D[g];
      localparam bit c_CPOL = (c_POL[g] != 0);
      localparam bit c_CPHA = (c_PHA[g] != 0);
      localparam bit c_MSBF = (c_MSB[g] != 0);
      localparam int c_L    = (2 * c_DW + 2) * c_DV + 1;

      logic            rstn  = 1'b0;
      logic            start = 1'b0;
      logic [c_DW-1:0] tx    = '0;
      logic [c_DW-1:0] rx;
      logic            busy, done, cs_n, sclk, mosi;
      logic            miso  = 1'b0;
      logic            fin_l = 1'b0;

      // Slave model state
      logic [c_DW-1:0] slv_word = '0;
      logic [c_DW-1:0] s_cap    = '0;
      int              s_cnt    = 0;
      int              s_drv    = 0;
      logic            prev_sclk = c_CPOL;
      logic            prev_cs   = 1'b1;

      spi_shift_engine #(
         .DATA_W    (c_DW),
         .CLK_DIV   (c_DV),
         .CPOL      (c_CPOL),
         .CPHA      (c_CPHA),
         .MSB_FIRST (c_MSBF)
      ) u_dut (
         .clk_i     (clk),
         .rstn_i    (rstn),
         .start_i   (start),
         .tx_data_i (tx),
         .rx_data_o (rx),
         .busy_o    (busy),
         .done_o    (done),
         .cs_n_o    (cs_n),
         .sclk_o    (sclk),
         .mosi_o    (mosi),
`ifdef SPI_SHIFT_ENGINE_LOOPBACK_EN
         .loopback_i(1'b0),
`endif
         .miso_i    (miso)
      );

      // Bit position of the k-th bit on the wire
      function automatic int pos(input int k);
         return c_MSBF ? (c_DW - 1 - k) : k;
      endfunction

      function automatic string tg(input string s);
         return $sformatf("c%0d_%s", g, s);
      endfunction

      // SPI slave: reacts to CS and SCLK edges as a real device would
      always @(negedge clk) begin
         prev_sclk <= sclk;
         prev_cs   <= cs_n;
         if (prev_cs && !cs_n) begin
            s_cnt <= 0;
            s_cap <= '0;
            if (!c_CPHA) begin
               miso  <= slv_word[pos(0)];
               s_drv <= 1;
            end else begin
               s_drv <= 0;
            end
         end else if (!cs_n && (sclk != prev_sclk)) begin
            if ((sclk != c_CPOL) == !c_CPHA) begin
               if (s_cnt < c_DW) s_cap[pos(s_cnt)] <= mosi;
               s_cnt <= s_cnt + 1;
            end else begin
               if (s_drv < c_DW) miso <= slv_word[pos(s_drv)];
               s_drv <= s_drv + 1;
            end
         end
      end

      task automatic xfer(input logic [c_DW-1:0] tx_v, input logic [c_DW-1:0] sw_v, input string nm);
         int lat;
         int csl;
         slv_word = sw_v;
         tx       = tx_v;
         start    = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         tx    = ~tx_v;
         lat = -1;
         csl = 0;
         for (int n = 1; n <= c_L + 4; n++) begin
            if (done) begin
               lat = n;
               break;
            end
            if (!cs_n) csl++;
            @(posedge clk); #1;
         end
         chk(tg({nm, "_latency"}), lat, c_L);
         chk(tg({nm, "_cs_low"}), csl, c_L - 1);
         chk(tg({nm, "_rx"}), rx, sw_v);
         chk(tg({nm, "_mosi_word"}), s_cap, tx_v);
         chk(tg({nm, "_cs_done"}), cs_n, 1);
         chk(tg({nm, "_mosi_done"}), mosi, 0);
         @(posedge clk); #1;
         chk(tg({nm, "_idle_busy"}), busy, 0);
         chk(tg({nm, "_idle_sclk"}), sclk, c_CPOL);
      endtask

      initial begin : g_run
         logic [31:0]     rv;
         logic [c_DW-1:0] a, b, sa, sb;
         int              nd, nb, lat;

         repeat (3) @(posedge clk);
         #1;
         chk(tg("rst_pins"), {cs_n, sclk, mosi, busy, done}, {1'b1, c_CPOL, 3'b000});
         chk(tg("rst_rx"), rx, 0);
         rstn = 1'b1;
         @(posedge clk); #1;

         // Directed transfer
         rv = c_TX0[g]; a  = rv[c_DW-1:0];
         rv = c_SW0[g]; sa = rv[c_DW-1:0];
         xfer(a, sa, "dir");

         // Random transfers
         for (int i = 0; i < 5; i++) begin
            rv = $urandom(); a  = rv[c_DW-1:0];
            rv = $urandom(); sa = rv[c_DW-1:0] | 1;
            xfer(a, sa, "rnd");
         end

         // start held high through a transfer and its DONE cycle
         rv = $urandom(); a  = rv[c_DW-1:0];
         rv = $urandom(); b  = rv[c_DW-1:0];
         rv = $urandom(); sa = rv[c_DW-1:0];
         rv = $urandom(); sb = rv[c_DW-1:0] | 1;
         slv_word = sa;
         tx       = a;
         start    = 1'b1;
         @(posedge clk); #1;
         tx = b;
         nd = 0;
         for (int n = 1; n < c_L; n++) begin
            if (done) nd++;
            @(posedge clk); #1;
         end
         chk(tg("held_early_done"), nd, 0);
         chk(tg("held_done"), done, 1);
         chk(tg("held_rx1"), rx, sa);
         chk(tg("held_mosi1"), s_cap, a);
         slv_word = sb;
         @(posedge clk); #1;
         chk(tg("held_idle"), busy, 0);
         @(posedge clk); #1;
         start = 1'b0;
         chk(tg("held_restart"), busy, 1);
         lat = -1;
         for (int n = 1; n <= c_L + 4; n++) begin
            if (done) begin
               lat = n;
               break;
            end
            @(posedge clk); #1;
         end
         chk(tg("held_latency2"), lat, c_L);
         chk(tg("held_rx2"), rx, sb);
         chk(tg("held_mosi2"), s_cap, b);
         @(posedge clk); #1;

         // Reset asserted at the start of SHIFT bit 4
         rv = $urandom(); slv_word = rv[c_DW-1:0];
         rv = $urandom(); tx = rv[c_DW-1:0];
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         repeat (9 * c_DV) @(posedge clk);
         #1;
         chk(tg("pre_rst_cs"), cs_n, 0);
         rstn = 1'b0;
         @(posedge clk); #1;
         chk(tg("abort_pins"), {cs_n, sclk, busy, done}, {1'b1, c_CPOL, 2'b00});
         chk(tg("abort_rx"), rx, 0);
         rstn = 1'b1;
         nd = 0;
         nb = 0;
         for (int n = 0; n < c_L + 2; n++) begin
            if (done) nd++;
            if (busy) nb++;
            @(posedge clk); #1;
         end
         chk(tg("abort_no_done"), nd, 0);
         chk(tg("abort_no_busy"), nb, 0);

         rv = $urandom(); a  = rv[c_DW-1:0];
         rv = $urandom(); sa = rv[c_DW-1:0];
         xfer(a, sa, "post_rst");
         fin_l = 1'b1;
      end
   end

   initial begin
      wait (g_cfg[0].fin_l && g_cfg[1].fin_l && g_cfg[2].fin_l);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      n_cmp++;
      n_bad++;
      $display("FAIL watchdog: got timeout, expected all configurations finished");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
